sample_frame_unpacker: RTL and testbench



---
 rtl/sample_link_pkg.sv | 25 ++
 rtl/seq_checker.sv | 51 +++++
 rtl/sample_frame_unpacker.sv | 173 +++++++++++++++++
 tb/tb_sample_frame_unpacker.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_link_pkg.sv
// Shared definitions for the packed 32-bit sample link.
// Word layout: [31] threshold flag, [30] reserved (must be 0),
// [29:16] 14-bit timestamp, [15:0] calibrated sample.
package sample_link_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam int FLAG_BIT = 31;
  localparam int RSVD_BIT = 30;
  localparam int TS_MSB   = 29;
  localparam int TS_LSB   = 16;
  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 0;
  localparam int TS_W     = 14;

  typedef enum logic [2:0] {
    ST_HUNT = 3'd0,
    ST_P3   = 3'd1,
    ST_P2   = 3'd2,
    ST_P1   = 3'd3,
    ST_P0   = 3'd4,
    ST_CSUM = 3'd5
  } state_t;

endpackage

// File: rtl/seq_checker.sv
// Timestamp continuity checker for decoded samples.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   i_load        - strobe: a good frame is being delivered this cycle
//   i_ts          - timestamp of that frame
//   o_gap         - registered gap flag of the most recently loaded frame
//   o_gap_count   - saturating count of gap events
module seq_checker
  import sample_link_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [TS_W-1:0]   i_ts,
  output logic              o_gap,
  output logic [CNT_W-1:0]  o_gap_count
);

  logic [TS_W-1:0]  r_last_ts;
  logic             r_first;
  logic             r_gap;
  logic [CNT_W-1:0] r_gap_count;

  logic [TS_W-1:0]  w_next_ts;
  logic             w_gap;

  // Natural 14-bit wrap makes 3FFF -> 0000 count as in-sequence.
  assign w_next_ts = r_last_ts + 1'b1;
  assign w_gap     = !r_first && (i_ts != w_next_ts);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_ts   <= '0;
      r_first     <= 1'b1;
      r_gap       <= 1'b0;
      r_gap_count <= '0;
    end else if (i_load) begin
      r_last_ts <= i_ts;
      r_first   <= 1'b0;
      r_gap     <= w_gap;
      if (w_gap && (r_gap_count != '1))
        r_gap_count <= r_gap_count + 1'b1;
    end
  end

  assign o_gap       = r_gap;
  assign o_gap_count = r_gap_count;

endmodule

// File: rtl/sample_frame_unpacker.sv
// Receive-side decoder for the packed sample link: hunts for the sync byte,
// assembles four big-endian payload bytes, validates the XOR checksum and
// reserved bit, and presents the unpacked sample with a ready/valid output.
//
// state   | meaning
// --------+-----------------------------------------------
// HUNT    | discarding bytes until SYNC_BYTE
// P3      | expecting W[31:24]
// P2      | expecting W[23:16]
// P1      | expecting W[15:8]
// P0      | expecting W[7:0]
// CSUM    | expecting checksum; stalls while output slot full
//
// Ports:
//   clk_100MHz, reset        - clock, asynchronous active-high reset
//   rx_byte/rx_valid/rx_ready - link byte input handshake
//   out_valid/out_ready       - sample output handshake
//   sample_flag/_timestamp/_data/_gap - unpacked sample fields
//   gap_count, error_count    - saturating event counters
//   frame_error               - one-cycle pulse per rejected frame
module sample_frame_unpacker
  import sample_link_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter int         CNT_W     = 16
) (
  input  logic              clk_100MHz,
  input  logic              reset,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sample_flag,
  output logic [TS_W-1:0]   sample_timestamp,
  output logic [15:0]       sample_data,
  output logic              sample_gap,
  output logic [CNT_W-1:0]  gap_count,
  output logic              frame_error,
  output logic [CNT_W-1:0]  error_count
);

  state_t           r_state;
  state_t           w_next_state;

  logic [31:0]      r_word;
  logic [7:0]       r_xor;
  logic             r_out_valid;
  logic             r_flag;
  logic [TS_W-1:0]  r_ts;
  logic [15:0]      r_data;
  logic             r_frame_error;
  logic [CNT_W-1:0] r_error_count;

  logic             w_rx_ready;
  logic             w_accept;
  logic             w_start;
  logic             w_shift;
  logic             w_load;
  logic             w_reject;

  // Only the checksum byte needs a free output slot; a slot being drained this
  // cycle counts as free, so delivery and refill can coincide.
  assign w_rx_ready = !((r_state == ST_CSUM) && r_out_valid && !out_ready);
  assign w_accept   = rx_valid && w_rx_ready;

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_shift      = 1'b0;
    w_load       = 1'b0;
    w_reject     = 1'b0;
    case (r_state)
      ST_HUNT: begin
        if (w_accept && (rx_byte == SYNC_BYTE)) begin
          w_start      = 1'b1;
          w_next_state = ST_P3;
        end
      end
      ST_P3: begin
        if (w_accept) begin
          w_shift      = 1'b1;
          w_next_state = ST_P2;
        end
      end
      ST_P2: begin
        if (w_accept) begin
          w_shift      = 1'b1;
          w_next_state = ST_P1;
        end
      end
      ST_P1: begin
        if (w_accept) begin
          w_shift      = 1'b1;
          w_next_state = ST_P0;
        end
      end
      ST_P0: begin
        if (w_accept) begin
          w_shift      = 1'b1;
          w_next_state = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (w_accept) begin
          if ((rx_byte == r_xor) && !r_word[RSVD_BIT])
            w_load = 1'b1;
          else
            w_reject = 1'b1;
          w_next_state = ST_HUNT;
        end
      end
      default: w_next_state = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_state       <= ST_HUNT;
      r_word        <= '0;
      r_xor         <= '0;
      r_out_valid   <= 1'b0;
      r_flag        <= 1'b0;
      r_ts          <= '0;
      r_data        <= '0;
      r_frame_error <= 1'b0;
      r_error_count <= '0;
    end else begin
      r_state <= w_next_state;

      if (w_start) begin
        r_word <= '0;
        r_xor  <= '0;
      end else if (w_shift) begin
        r_word <= {r_word[23:0], rx_byte};
        r_xor  <= r_xor ^ rx_byte;
      end

      r_frame_error <= w_reject;
      if (w_reject && (r_error_count != '1))
        r_error_count <= r_error_count + 1'b1;

      if (w_load) begin
        r_out_valid <= 1'b1;
        r_flag      <= r_word[FLAG_BIT];
        r_ts        <= r_word[TS_MSB:TS_LSB];
        r_data      <= r_word[DATA_MSB:DATA_LSB];
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  seq_checker #(
    .CNT_W (CNT_W)
  ) u_seq_checker (
    .clk         (clk_100MHz),
    .rst         (reset),
    .i_load      (w_load),
    .i_ts        (r_word[TS_MSB:TS_LSB]),
    .o_gap       (sample_gap),
    .o_gap_count (gap_count)
  );

  assign rx_ready         = w_rx_ready;
  assign out_valid        = r_out_valid;
  assign sample_flag      = r_flag;
  assign sample_timestamp = r_ts;
  assign sample_data      = r_data;
  assign frame_error      = r_frame_error;
  assign error_count      = r_error_count;

endmodule

// File: tb/tb_sample_frame_unpacker.sv
module tb_sample_frame_unpacker;

  localparam int CNT_W = 16;

  logic             clk_100MHz = 1'b0;
  logic             reset      = 1'b1;
  logic [7:0]       rx_byte    = 8'h00;
  logic             rx_valid   = 1'b0;
  logic             rx_ready;
  logic             out_valid;
  logic             out_ready  = 1'b1;
  logic             sample_flag;
  logic [13:0]      sample_timestamp;
  logic [15:0]      sample_data;
  logic             sample_gap;
  logic [CNT_W-1:0] gap_count;
  logic             frame_error;
  logic [CNT_W-1:0] error_count;

  always #5 clk_100MHz = ~clk_100MHz;

  sample_frame_unpacker #(
    .SYNC_BYTE (8'hA5),
    .CNT_W     (CNT_W)
  ) u_dut (
    .clk_100MHz       (clk_100MHz),
    .reset            (reset),
    .rx_byte          (rx_byte),
    .rx_valid         (rx_valid),
    .rx_ready         (rx_ready),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .sample_flag      (sample_flag),
    .sample_timestamp (sample_timestamp),
    .sample_data      (sample_data),
    .sample_gap       (sample_gap),
    .gap_count        (gap_count),
    .frame_error      (frame_error),
    .error_count      (error_count)
  );

  typedef struct {
    logic        flag;
    logic [13:0] ts;
    logic [15:0] data;
    logic        gap;
  } samp_t;

  samp_t       exp_q[$];
  int          n_cmp      = 0;
  int          n_fail     = 0;
  bit          m_first    = 1'b1;
  logic [13:0] m_last_ts  = '0;
  int          m_gap_cnt  = 0;
  int          m_err_cnt  = 0;
  int          n_err_seen = 0;
  int          ready_mode = 0;   // 0: always ready, 1: random, 2: never ready
  bit          bubbles    = 1'b0;
  logic        prev_fe    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] csum_of(input logic [31:0] w);
    return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction

  // Reference model: decides the outcome of a frame from the frame rules alone.
  task automatic model_frame(input logic [31:0] w, input bit bad);
    samp_t s;
    int    nxt;
    if (bad) begin
      m_err_cnt++;
    end else begin
      nxt    = (int'(m_last_ts) + 1) % 16384;
      s.flag = w[31];
      s.ts   = w[29:16];
      s.data = w[15:0];
      s.gap  = !m_first && (int'(w[29:16]) != nxt);
      if (s.gap && m_gap_cnt < 65535) m_gap_cnt++;
      m_first   = 1'b0;
      m_last_ts = w[29:16];
      exp_q.push_back(s);
    end
  endtask

  task automatic summary_and_fatal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "aborted");
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n   = 0;
    bit acc = 1'b0;
    if (bubbles && $urandom_range(0, 3) == 0) begin
      @(negedge clk_100MHz);
      rx_valid = 1'b0;
    end
    while (!acc) begin
      @(negedge clk_100MHz);
      rx_byte  = b;
      rx_valid = 1'b1;
      #4;
      acc = rx_ready;
      @(posedge clk_100MHz);
      n++;
      if (n > 2000) begin
        n_fail++;
        $display("FAIL send_byte_timeout: byte %0h never accepted", b);
        summary_and_fatal();
      end
    end
  endtask

  // Returns at the negedge after the checksum byte was accepted.
  task automatic send_frame(input logic [31:0] w, input logic [7:0] cmask);
    model_frame(w, (cmask != 8'h00) || w[30]);
    send_byte(8'hA5);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
    send_byte(csum_of(w) ^ cmask);
    @(negedge clk_100MHz);
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_100MHz);
    reset    = 1'b1;
    rx_valid = 1'b0;
    exp_q.delete();
    m_first    = 1'b1;
    m_last_ts  = '0;
    m_gap_cnt  = 0;
    m_err_cnt  = 0;
    n_err_seen = 0;
    repeat (2) @(negedge clk_100MHz);
    reset = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk_100MHz);
      n++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    repeat (3) @(negedge clk_100MHz);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"},   out_valid, 0);
    chk({tag, "_rx_ready"},    rx_ready, 1);
    chk({tag, "_flag"},        sample_flag, 0);
    chk({tag, "_ts"},          sample_timestamp, 0);
    chk({tag, "_data"},        sample_data, 0);
    chk({tag, "_gap"},         sample_gap, 0);
    chk({tag, "_gap_count"},   gap_count, 0);
    chk({tag, "_frame_error"}, frame_error, 0);
    chk({tag, "_error_count"}, error_count, 0);
  endtask

  always @(posedge clk_100MHz) begin
    #2;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Per-cycle compare against the model.
  always @(negedge clk_100MHz) begin
    if (!reset) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", out_valid, 0);
        end else begin
          chk("sample_flag", sample_flag, exp_q[0].flag);
          chk("sample_timestamp", sample_timestamp, exp_q[0].ts);
          chk("sample_data", sample_data, exp_q[0].data);
          chk("sample_gap", sample_gap, exp_q[0].gap);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (frame_error) begin
        n_err_seen++;
        chk("error_count_track", error_count, n_err_seen);
        chk("frame_error_single_cycle", prev_fe, 0);
      end
      prev_fe = frame_error;
    end else begin
      prev_fe = 1'b0;
    end
  end

  initial begin
    logic [31:0] w;
    logic [13:0] ts;
    logic [7:0]  g;
    int          r;

    do_reset();
    chk_reset_state("reset");

    chk("model_csum_vec1", csum_of(32'h12345678), 8'h08);
    chk("model_csum_vec2", csum_of(32'h80010005), 8'h84);

    // Basic frame, one-cycle latency.
    send_frame(32'h12345678, 8'h00);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_flag", sample_flag, 0);
    chk("t1_ts", sample_timestamp, 14'h1234);
    chk("t1_data", sample_data, 16'h5678);
    chk("t1_gap", sample_gap, 0);
    drain();

    // Garbage before sync is discarded.
    send_byte(8'h00);
    send_byte(8'hFF);
    send_frame(32'h80010005, 8'h00);
    chk("t2_out_valid", out_valid, 1);
    chk("t2_flag", sample_flag, 1);
    chk("t2_ts", sample_timestamp, 14'h0001);
    chk("t2_data", sample_data, 16'h0005);
    chk("t2_gap", sample_gap, 1);
    drain();

    // Timestamp wrap and a real gap.
    do_reset();
    send_frame({2'b00, 14'h3FFE, 16'h0101}, 8'h00);
    chk("t3_gap0", sample_gap, 0);
    send_frame({2'b00, 14'h3FFF, 16'h0202}, 8'h00);
    chk("t3_gap1", sample_gap, 0);
    send_frame({2'b00, 14'h0000, 16'h0303}, 8'h00);
    chk("t3_gap2_wrap", sample_gap, 0);
    send_frame({2'b00, 14'h0002, 16'h0404}, 8'h00);
    chk("t3_gap3", sample_gap, 1);
    drain();
    chk("t3_gap_count", gap_count, 1);

    // Rejected frames: bad checksum and reserved bit set.
    send_frame({2'b00, 14'h0003, 16'h1111}, 8'h40);
    chk("t4_fe_csum", frame_error, 1);
    chk("t4_no_valid_csum", out_valid, 0);
    send_frame({2'b01, 14'h0003, 16'h2222}, 8'h00);
    chk("t4_fe_rsvd", frame_error, 1);
    chk("t4_no_valid_rsvd", out_valid, 0);
    drain();
    chk("t4_error_count", error_count, 2);
    send_frame({2'b00, 14'h0003, 16'h3333}, 8'h00);
    chk("t4_no_gap_after_reject", sample_gap, 0);
    drain();
    chk("t4_gap_count", gap_count, 1);

    // Back-pressure: second checksum byte stalls while first sample is held.
    ready_mode = 2;
    repeat (2) @(negedge clk_100MHz);
    send_frame({2'b00, 14'h0004, 16'hAAAA}, 8'h00);
    w = {2'b00, 14'h0005, 16'hBBBB};
    model_frame(w, 1'b0);
    send_byte(8'hA5);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
    @(negedge clk_100MHz);
    rx_byte  = csum_of(w);
    rx_valid = 1'b1;
    repeat (3) begin
      @(negedge clk_100MHz);
      chk("t5_rx_ready_stall", rx_ready, 0);
      chk("t5_held_valid", out_valid, 1);
      chk("t5_held_data", sample_data, 16'hAAAA);
    end
    ready_mode = 0;
    send_byte(csum_of(w));
    @(negedge clk_100MHz);
    rx_valid = 1'b0;
    drain();
    chk("t5_gap_count", gap_count, 1);

    // Reset mid-frame.
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h07);
    do_reset();
    chk_reset_state("midreset");
    send_frame({2'b00, 14'h0100, 16'hBEEF}, 8'h00);
    chk("t6_out_valid", out_valid, 1);
    chk("t6_ts", sample_timestamp, 14'h0100);
    chk("t6_data", sample_data, 16'hBEEF);
    chk("t6_gap_first", sample_gap, 0);
    drain();

    // Randomized traffic with bubbles and random back-pressure.
    bubbles    = 1'b1;
    ready_mode = 1;
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h5A;
        send_byte(g);
      end
      r = int'($urandom_range(0, 9));
      if (r <= 5) ts = m_last_ts + 14'd1;
      else        ts = 14'($urandom_range(0, 16383));
      w = {1'($urandom_range(0, 1)), 1'b0, ts, 16'($urandom_range(0, 65535))};
      if (r == 7)      send_frame(w, 8'($urandom_range(1, 255)));
      else if (r == 8) send_frame(w | 32'h4000_0000, 8'h00);
      else             send_frame(w, 8'h00);
    end
    ready_mode = 0;
    drain();
    chk("final_gap_count", gap_count, m_gap_cnt);
    chk("final_error_count", error_count, m_err_cnt);
    chk("final_error_pulses", n_err_seen, m_err_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
